dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_pkg.sv | 29 ++
 rtl/dispatch_queue_if.sv | 87 ++++++++
 rtl/dispatch_queue_operand_resolve.sv | 53 +++++
 rtl/dispatch_queue.sv | 165 ++++++++++++++++
 tb/tb_dispatch_queue.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared widths, op-type encodings and boolean constants for the dispatch queue
// and its operand resolver.
package dispatch_queue_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_NUM_CDB = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ROB_W   = 4;
  localparam int DEF_REG_W   = 5;
  localparam int DEF_OP_W    = 6;
  localparam int DEF_OPT_W   = 3;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [DEF_OPT_W-1:0] {
    OPT_ARITH  = 3'd0,
    OPT_JUMP   = 3'd1,
    OPT_BRANCH = 3'd2,
    OPT_LOAD   = 3'd3,
    OPT_STORE  = 3'd4
  } op_type_e;

  // ARITH/JUMP/BRANCH go to the reservation station; everything else to the LSB.
  function automatic logic to_rs(input logic [DEF_OPT_W-1:0] op_type);
    return (op_type == OPT_ARITH) || (op_type == OPT_JUMP) || (op_type == OPT_BRANCH);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Bundle of every dispatch-queue signal except clock and reset.
// Decoder handshake: an instruction transfers on a rising edge where dec_valid_in
// and dec_ready_out are both high (and rdy_in high, flush_in low); dec_ready_out
// never looks at dec_valid_in, and a valid instruction stays stable until taken.
interface dispatch_queue_if import dispatch_queue_pkg::*; #(
  parameter int NUM_CDB = DEF_NUM_CDB,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROB_W   = DEF_ROB_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int OPT_W   = DEF_OPT_W
);
  logic                      rdy_in;
  logic                      flush_in;
  logic                      dec_valid_in;
  logic                      dec_ready_out;
  logic [DATA_W-1:0]         dec_pc_in;
  logic [DATA_W-1:0]         dec_imm_in;
  logic [OPT_W-1:0]          dec_op_type_in;
  logic [OP_W-1:0]           dec_opcode_in;
  logic [REG_W-1:0]          dec_rs1_in;
  logic [REG_W-1:0]          dec_rs2_in;
  logic [REG_W-1:0]          dec_rd_in;
  logic [REG_W-1:0]          rf_rs1_out;
  logic [REG_W-1:0]          rf_rs2_out;
  logic                      rf_busy1_in;
  logic                      rf_busy2_in;
  logic [DATA_W-1:0]         rf_val1_in;
  logic [DATA_W-1:0]         rf_val2_in;
  logic [ROB_W-1:0]          rf_tag1_in;
  logic [ROB_W-1:0]          rf_tag2_in;
  logic                      rf_rename_valid_out;
  logic [REG_W-1:0]          rf_rename_rd_out;
  logic [ROB_W-1:0]          rf_rename_tag_out;
  logic                      rob_full_in;
  logic [ROB_W-1:0]          rob_tag_in;
  logic [ROB_W-1:0]          rob_q1_out;
  logic [ROB_W-1:0]          rob_q2_out;
  logic                      rob_rdy1_in;
  logic                      rob_rdy2_in;
  logic [DATA_W-1:0]         rob_val1_in;
  logic [DATA_W-1:0]         rob_val2_in;
  logic                      rob_alloc_out;
  logic [OPT_W-1:0]          rob_op_type_out;
  logic [REG_W-1:0]          rob_dest_out;
  logic [NUM_CDB-1:0]        cdb_valid_in;
  logic [NUM_CDB*ROB_W-1:0]  cdb_tag_in;
  logic [NUM_CDB*DATA_W-1:0] cdb_val_in;
  logic                      rs_full_in;
  logic                      lsb_full_in;
  logic                      rs_valid_out;
  logic                      lsb_valid_out;
  logic [OP_W-1:0]           iss_opcode_out;
  logic [DATA_W-1:0]         iss_pc_out;
  logic [DATA_W-1:0]         iss_imm_out;
  logic [DATA_W-1:0]         iss_vj_out;
  logic [DATA_W-1:0]         iss_vk_out;
  logic [ROB_W-1:0]          iss_qj_out;
  logic [ROB_W-1:0]          iss_qk_out;
  logic [ROB_W-1:0]          iss_tag_out;

  modport slave (
    input  rdy_in, flush_in, dec_valid_in, dec_pc_in, dec_imm_in, dec_op_type_in,
           dec_opcode_in, dec_rs1_in, dec_rs2_in, dec_rd_in,
           rf_busy1_in, rf_busy2_in, rf_val1_in, rf_val2_in, rf_tag1_in, rf_tag2_in,
           rob_full_in, rob_tag_in, rob_rdy1_in, rob_rdy2_in, rob_val1_in, rob_val2_in,
           cdb_valid_in, cdb_tag_in, cdb_val_in, rs_full_in, lsb_full_in,
    output dec_ready_out, rf_rs1_out, rf_rs2_out,
           rf_rename_valid_out, rf_rename_rd_out, rf_rename_tag_out,
           rob_q1_out, rob_q2_out, rob_alloc_out, rob_op_type_out, rob_dest_out,
           rs_valid_out, lsb_valid_out, iss_opcode_out, iss_pc_out, iss_imm_out,
           iss_vj_out, iss_vk_out, iss_qj_out, iss_qk_out, iss_tag_out
  );

  modport master (
    output rdy_in, flush_in, dec_valid_in, dec_pc_in, dec_imm_in, dec_op_type_in,
           dec_opcode_in, dec_rs1_in, dec_rs2_in, dec_rd_in,
           rf_busy1_in, rf_busy2_in, rf_val1_in, rf_val2_in, rf_tag1_in, rf_tag2_in,
           rob_full_in, rob_tag_in, rob_rdy1_in, rob_rdy2_in, rob_val1_in, rob_val2_in,
           cdb_valid_in, cdb_tag_in, cdb_val_in, rs_full_in, lsb_full_in,
    input  dec_ready_out, rf_rs1_out, rf_rs2_out,
           rf_rename_valid_out, rf_rename_rd_out, rf_rename_tag_out,
           rob_q1_out, rob_q2_out, rob_alloc_out, rob_op_type_out, rob_dest_out,
           rs_valid_out, lsb_valid_out, iss_opcode_out, iss_pc_out, iss_imm_out,
           iss_vj_out, iss_vk_out, iss_qj_out, iss_qk_out, iss_tag_out
  );
endinterface

// File: rtl/dispatch_queue_operand_resolve.sv
// Resolves one source operand to either a value (q=0) or a pending ROB tag,
// looking at the register file, the result broadcasts and the ROB in that order.
module operand_resolve import dispatch_queue_pkg::*; #(
  parameter int NUM_CDB = DEF_NUM_CDB,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROB_W   = DEF_ROB_W,
  parameter int REG_W   = DEF_REG_W
) (
  input  logic [REG_W-1:0]          rs,
  input  logic                      rf_busy,
  input  logic [DATA_W-1:0]         rf_val,
  input  logic [ROB_W-1:0]          rf_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
  input  logic                      rob_rdy,
  input  logic [DATA_W-1:0]         rob_val,
  output logic [DATA_W-1:0]         v,
  output logic [ROB_W-1:0]          q
);

  logic              cdb_hit;
  logic [DATA_W-1:0] cdb_sel;

  // Scan from the top so the lowest-index matching port is the last writer.
  always_comb begin
    cdb_hit = FALSE;
    cdb_sel = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == rf_tag)) begin
        cdb_hit = TRUE;
        cdb_sel = cdb_val[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    v = '0;
    q = '0;
    if (rs != '0) begin
      if (rf_busy == FALSE) begin
        v = rf_val;
      end else if (cdb_hit) begin
        v = cdb_sel;
      end else if (rob_rdy) begin
        v = rob_val;
      end else begin
        q = rf_tag;
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction buffer between decode and the RS/LSB: renames the head,
// allocates its ROB entry and issues it with resolved operands one cycle later.
module dispatch_queue import dispatch_queue_pkg::*; #(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_CDB = DEF_NUM_CDB,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROB_W   = DEF_ROB_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int OPT_W   = DEF_OPT_W
) (
  input logic            clk_in,
  input logic            rst_in,
  dispatch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] pc_mem  [DEPTH];
  logic [DATA_W-1:0] imm_mem [DEPTH];
  logic [OPT_W-1:0]  opt_mem [DEPTH];
  logic [OP_W-1:0]   opc_mem [DEPTH];
  logic [REG_W-1:0]  rs1_mem [DEPTH];
  logic [REG_W-1:0]  rs2_mem [DEPTH];
  logic [REG_W-1:0]  rd_mem  [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              head_rs;
  logic              target_full;
  logic              enq;
  logic              dispatch;

  logic [DATA_W-1:0] vj;
  logic [DATA_W-1:0] vk;
  logic [ROB_W-1:0]  qj;
  logic [ROB_W-1:0]  qk;

  logic              rs_valid_q;
  logic              lsb_valid_q;
  logic [OP_W-1:0]   opcode_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] vj_q;
  logic [DATA_W-1:0] vk_q;
  logic [ROB_W-1:0]  qj_q;
  logic [ROB_W-1:0]  qk_q;
  logic [ROB_W-1:0]  tag_q;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign head_rs     = to_rs(opt_mem[head]);
  assign target_full = head_rs ? bus.rs_full_in : bus.lsb_full_in;

  // Reset and flush both kill the combinational pulses in the same cycle.
  assign enq      = !rst_in && bus.rdy_in && !bus.flush_in && bus.dec_valid_in && !full;
  assign dispatch = !rst_in && bus.rdy_in && !bus.flush_in && !empty &&
                    !bus.rob_full_in && !target_full;

  assign bus.dec_ready_out       = !full;
  assign bus.rf_rs1_out          = rs1_mem[head];
  assign bus.rf_rs2_out          = rs2_mem[head];
  assign bus.rob_q1_out          = bus.rf_tag1_in;
  assign bus.rob_q2_out          = bus.rf_tag2_in;
  assign bus.rob_alloc_out       = dispatch;
  assign bus.rob_op_type_out     = opt_mem[head];
  assign bus.rob_dest_out        = rd_mem[head];
  assign bus.rf_rename_valid_out = dispatch && (rd_mem[head] != '0);
  assign bus.rf_rename_rd_out    = rd_mem[head];
  assign bus.rf_rename_tag_out   = bus.rob_tag_in;

  operand_resolve #(
    .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .ROB_W(ROB_W), .REG_W(REG_W)
  ) u_src1 (
    .rs(rs1_mem[head]), .rf_busy(bus.rf_busy1_in), .rf_val(bus.rf_val1_in),
    .rf_tag(bus.rf_tag1_in), .cdb_valid(bus.cdb_valid_in), .cdb_tag(bus.cdb_tag_in),
    .cdb_val(bus.cdb_val_in), .rob_rdy(bus.rob_rdy1_in), .rob_val(bus.rob_val1_in),
    .v(vj), .q(qj)
  );

  operand_resolve #(
    .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .ROB_W(ROB_W), .REG_W(REG_W)
  ) u_src2 (
    .rs(rs2_mem[head]), .rf_busy(bus.rf_busy2_in), .rf_val(bus.rf_val2_in),
    .rf_tag(bus.rf_tag2_in), .cdb_valid(bus.cdb_valid_in), .cdb_tag(bus.cdb_tag_in),
    .cdb_val(bus.cdb_val_in), .rob_rdy(bus.rob_rdy2_in), .rob_val(bus.rob_val2_in),
    .v(vk), .q(qk)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq)      tail <= tail + PTR_W'(1);
        if (dispatch) head <= head + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(dispatch);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq) begin
      pc_mem[tail]  <= bus.dec_pc_in;
      imm_mem[tail] <= bus.dec_imm_in;
      opt_mem[tail] <= bus.dec_op_type_in;
      opc_mem[tail] <= bus.dec_opcode_in;
      rs1_mem[tail] <= bus.dec_rs1_in;
      rs2_mem[tail] <= bus.dec_rs2_in;
      rd_mem[tail]  <= bus.dec_rd_in;
    end
  end

  // Issue bundle: data holds between dispatches, valids are one-cycle pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rs_valid_q  <= 1'b0;
      lsb_valid_q <= 1'b0;
      opcode_q    <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      vj_q        <= '0;
      vk_q        <= '0;
      qj_q        <= '0;
      qk_q        <= '0;
      tag_q       <= '0;
    end else begin
      rs_valid_q  <= dispatch && head_rs;
      lsb_valid_q <= dispatch && !head_rs;
      if (dispatch) begin
        opcode_q <= opc_mem[head];
        pc_q     <= pc_mem[head];
        imm_q    <= imm_mem[head];
        vj_q     <= vj;
        vk_q     <= vk;
        qj_q     <= qj;
        qk_q     <= qk;
        tag_q    <= bus.rob_tag_in;
      end
    end
  end

  assign bus.rs_valid_out   = rs_valid_q;
  assign bus.lsb_valid_out  = lsb_valid_q;
  assign bus.iss_opcode_out = opcode_q;
  assign bus.iss_pc_out     = pc_q;
  assign bus.iss_imm_out    = imm_q;
  assign bus.iss_vj_out     = vj_q;
  assign bus.iss_vk_out     = vk_q;
  assign bus.iss_qj_out     = qj_q;
  assign bus.iss_qk_out     = qk_q;
  assign bus.iss_tag_out    = tag_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int NC    = 2;
  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam int GW    = 5;
  localparam int OW    = 6;
  localparam int TW    = 3;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [TW-1:0] opt;
    logic [OW-1:0] opc;
    logic [GW-1:0] rs1;
    logic [GW-1:0] rs2;
    logic [GW-1:0] rd;
  } ent_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ent_t mq[$];
  logic          e_rs_v, e_lsb_v;
  logic [OW-1:0] e_opc;
  logic [DW-1:0] e_pc, e_imm, e_vj, e_vk;
  logic [RW-1:0] e_qj, e_qk, e_tag;

  dispatch_queue_if bus ();

  dispatch_queue #(
    .DEPTH(DEPTH), .NUM_CDB(NC), .DATA_W(DW), .ROB_W(RW), .REG_W(GW), .OP_W(OW), .OPT_W(TW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic goes_rs(input logic [TW-1:0] opt);
    return opt < 3;
  endfunction

  // Priority list: reg0, RF ready, first matching broadcast, ROB ready, wait on tag.
  function automatic void resolve(input logic [GW-1:0] r, input logic busy,
                                  input logic [DW-1:0] rfv, input logic [RW-1:0] tag,
                                  input logic rrdy, input logic [DW-1:0] rv,
                                  output logic [DW-1:0] v, output logic [RW-1:0] q);
    v = '0;
    q = '0;
    if (r == 0) return;
    if (!busy) begin
      v = rfv;
      return;
    end
    for (int i = 0; i < NC; i++) begin
      if (bus.cdb_valid_in[i] && bus.cdb_tag_in[i*RW +: RW] == tag) begin
        v = bus.cdb_val_in[i*DW +: DW];
        return;
      end
    end
    if (rrdy) begin
      v = rv;
      return;
    end
    q = tag;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 1'b0;
    bus.rdy_in = 1'b1;          bus.flush_in = 1'b0;
    bus.dec_valid_in = 1'b0;    bus.dec_pc_in = '0;      bus.dec_imm_in = '0;
    bus.dec_op_type_in = '0;    bus.dec_opcode_in = '0;
    bus.dec_rs1_in = '0;        bus.dec_rs2_in = '0;     bus.dec_rd_in = '0;
    bus.rf_busy1_in = 1'b0;     bus.rf_busy2_in = 1'b0;
    bus.rf_val1_in = '0;        bus.rf_val2_in = '0;
    bus.rf_tag1_in = 4'd1;      bus.rf_tag2_in = 4'd1;
    bus.rob_full_in = 1'b0;     bus.rob_tag_in = 4'd1;
    bus.rob_rdy1_in = 1'b0;     bus.rob_rdy2_in = 1'b0;
    bus.rob_val1_in = '0;       bus.rob_val2_in = '0;
    bus.cdb_valid_in = '0;      bus.cdb_tag_in = '0;     bus.cdb_val_in = '0;
    bus.rs_full_in = 1'b0;      bus.lsb_full_in = 1'b0;
  endtask

  task automatic set_dec(input logic [TW-1:0] opt, input logic [OW-1:0] opc,
                         input logic [GW-1:0] rs1, input logic [GW-1:0] rs2,
                         input logic [GW-1:0] rd, input logic [DW-1:0] pc,
                         input logic [DW-1:0] imm);
    bus.dec_valid_in = 1'b1;  bus.dec_op_type_in = opt; bus.dec_opcode_in = opc;
    bus.dec_rs1_in = rs1;     bus.dec_rs2_in = rs2;     bus.dec_rd_in = rd;
    bus.dec_pc_in = pc;       bus.dec_imm_in = imm;
  endtask

  // One clock cycle: check combinational outputs against the model, advance the
  // model, cross the edge, then check the registered issue bundle.
  task automatic tick();
    ent_t h;
    ent_t n;
    bit   has, disp, enq;
    h = '{default: '0};
    #1;
    has = mq.size() > 0;
    if (has) h = mq[0];
    disp = !rst && bus.rdy_in && !bus.flush_in && has && !bus.rob_full_in &&
           !(goes_rs(h.opt) ? bus.rs_full_in : bus.lsb_full_in);
    enq  = !rst && bus.rdy_in && !bus.flush_in && bus.dec_valid_in && mq.size() < DEPTH;

    chk("dec_ready", bus.dec_ready_out, mq.size() < DEPTH);
    chk("rob_alloc", bus.rob_alloc_out, disp);
    chk("rename_valid", bus.rf_rename_valid_out, disp && h.rd != 0);
    chk("rob_q1", bus.rob_q1_out, bus.rf_tag1_in);
    chk("rob_q2", bus.rob_q2_out, bus.rf_tag2_in);
    if (has) begin
      chk("rf_rs1", bus.rf_rs1_out, h.rs1);
      chk("rf_rs2", bus.rf_rs2_out, h.rs2);
    end
    if (disp) begin
      chk("rob_op_type", bus.rob_op_type_out, h.opt);
      chk("rob_dest", bus.rob_dest_out, h.rd);
      chk("rename_rd", bus.rf_rename_rd_out, h.rd);
      chk("rename_tag", bus.rf_rename_tag_out, bus.rob_tag_in);
    end

    if (rst) begin
      mq.delete();
      e_rs_v = 0; e_lsb_v = 0; e_opc = '0; e_pc = '0; e_imm = '0;
      e_vj = '0; e_vk = '0; e_qj = '0; e_qk = '0; e_tag = '0;
    end else begin
      e_rs_v  = disp && goes_rs(h.opt);
      e_lsb_v = disp && !goes_rs(h.opt);
      if (disp) begin
        e_opc = h.opc; e_pc = h.pc; e_imm = h.imm; e_tag = bus.rob_tag_in;
        resolve(h.rs1, bus.rf_busy1_in, bus.rf_val1_in, bus.rf_tag1_in,
                bus.rob_rdy1_in, bus.rob_val1_in, e_vj, e_qj);
        resolve(h.rs2, bus.rf_busy2_in, bus.rf_val2_in, bus.rf_tag2_in,
                bus.rob_rdy2_in, bus.rob_val2_in, e_vk, e_qk);
      end
      if (bus.rdy_in && bus.flush_in) begin
        mq.delete();
      end else begin
        if (disp) void'(mq.pop_front());
        if (enq) begin
          n.pc = bus.dec_pc_in; n.imm = bus.dec_imm_in; n.opt = bus.dec_op_type_in;
          n.opc = bus.dec_opcode_in; n.rs1 = bus.dec_rs1_in; n.rs2 = bus.dec_rs2_in;
          n.rd = bus.dec_rd_in;
          mq.push_back(n);
        end
      end
    end

    @(posedge clk);
    #1;
    chk("rs_valid", bus.rs_valid_out, e_rs_v);
    chk("lsb_valid", bus.lsb_valid_out, e_lsb_v);
    chk("iss_opcode", bus.iss_opcode_out, e_opc);
    chk("iss_pc", bus.iss_pc_out, e_pc);
    chk("iss_imm", bus.iss_imm_out, e_imm);
    chk("iss_vj", bus.iss_vj_out, e_vj);
    chk("iss_qj", bus.iss_qj_out, e_qj);
    chk("iss_vk", bus.iss_vk_out, e_vk);
    chk("iss_qk", bus.iss_qk_out, e_qk);
    chk("iss_tag", bus.iss_tag_out, e_tag);
  endtask

  // Enqueue one ARITH instruction, leave the decoder idle afterwards.
  task automatic push_arith(input logic [GW-1:0] rs1, input logic [GW-1:0] rd,
                            input logic [DW-1:0] pc);
    set_dec(OPT_ARITH, 6'h01, rs1, 5'd0, rd, pc, 32'h0);
    tick();
    bus.dec_valid_in = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus.rdy_in       = ($urandom_range(0, 9) != 0);
    bus.flush_in     = bus.rdy_in && ($urandom_range(0, 19) == 0);
    rst              = ($urandom_range(0, 99) == 0);
    bus.dec_valid_in = ($urandom_range(0, 9) < 6);
    bus.dec_pc_in    = $urandom;
    bus.dec_imm_in   = $urandom;
    bus.dec_op_type_in = TW'($urandom_range(0, 4));
    bus.dec_opcode_in  = OW'($urandom);
    bus.dec_rs1_in   = GW'($urandom_range(0, 7));
    bus.dec_rs2_in   = GW'($urandom_range(0, 7));
    bus.dec_rd_in    = GW'($urandom_range(0, 3));
    bus.rf_busy1_in  = $urandom_range(0, 1);
    bus.rf_busy2_in  = $urandom_range(0, 1);
    bus.rf_val1_in   = $urandom;
    bus.rf_val2_in   = $urandom;
    bus.rf_tag1_in   = RW'($urandom_range(1, 15));
    bus.rf_tag2_in   = RW'($urandom_range(1, 15));
    bus.rob_full_in  = ($urandom_range(0, 4) == 0);
    bus.rob_tag_in   = RW'($urandom_range(1, 15));
    bus.rob_rdy1_in  = $urandom_range(0, 1);
    bus.rob_rdy2_in  = $urandom_range(0, 1);
    bus.rob_val1_in  = $urandom;
    bus.rob_val2_in  = $urandom;
    bus.rs_full_in   = ($urandom_range(0, 3) == 0);
    bus.lsb_full_in  = ($urandom_range(0, 3) == 0);
    for (int p = 0; p < NC; p++) begin
      bus.cdb_valid_in[p] = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       bus.cdb_tag_in[p*RW +: RW] = bus.rf_tag1_in;
        1:       bus.cdb_tag_in[p*RW +: RW] = bus.rf_tag2_in;
        default: bus.cdb_tag_in[p*RW +: RW] = RW'($urandom_range(1, 15));
      endcase
      bus.cdb_val_in[p*DW +: DW] = $urandom;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    errors = 0;
    checks = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    e_rs_v = 0; e_lsb_v = 0; e_opc = '0; e_pc = '0; e_imm = '0;
    e_vj = '0; e_vk = '0; e_qj = '0; e_qk = '0; e_tag = '0;

    chk("reset_ready", bus.dec_ready_out, 1);
    chk("reset_rs_valid", bus.rs_valid_out, 0);
    chk("reset_lsb_valid", bus.lsb_valid_out, 0);
    chk("reset_vj", bus.iss_vj_out, 0);

    // ADD rs1=1 (ready, 5), rs2=0: issue two cycles after enqueue.
    bus.rf_val1_in = 32'd5;
    bus.rob_tag_in = 4'd7;
    push_arith(5'd1, 5'd2, 32'h1000);
    tick();
    chk("t1_rs_valid", bus.rs_valid_out, 1);
    chk("t1_vj", bus.iss_vj_out, 32'd5);
    chk("t1_qj", bus.iss_qj_out, 0);
    chk("t1_vk", bus.iss_vk_out, 0);
    chk("t1_tag", bus.iss_tag_out, 4'd7);
    tick();
    chk("t1_pulse_once", bus.rs_valid_out, 0);

    // rs1 busy on tag 3, ROB not ready, broadcast port 1 carries tag 3.
    idle();
    push_arith(5'd3, 5'd4, 32'h2000);
    bus.rf_busy1_in = 1'b1;  bus.rf_tag1_in = 4'd3;
    bus.cdb_valid_in = 2'b10;
    bus.cdb_tag_in = {4'd3, 4'd5};
    bus.cdb_val_in = {32'h77, 32'h55};
    tick();
    chk("t2_vj_cdb1", bus.iss_vj_out, 32'h77);
    chk("t2_qj_cdb1", bus.iss_qj_out, 0);

    // Both ports match: the lower index wins.
    idle();
    push_arith(5'd3, 5'd4, 32'h2004);
    bus.rf_busy1_in = 1'b1;  bus.rf_tag1_in = 4'd3;
    bus.cdb_valid_in = 2'b11;
    bus.cdb_tag_in = {4'd3, 4'd3};
    bus.cdb_val_in = {32'h77, 32'h11};
    tick();
    chk("t2_vj_cdb0", bus.iss_vj_out, 32'h11);

    // No broadcast, ROB not ready: operand waits on the RF tag.
    idle();
    push_arith(5'd3, 5'd4, 32'h2008);
    bus.rf_busy1_in = 1'b1;  bus.rf_tag1_in = 4'd9;
    tick();
    chk("t2_wait_qj", bus.iss_qj_out, 4'd9);
    chk("t2_wait_vj", bus.iss_vj_out, 0);

    // Fill with loads while LSB is full, then drain in program order.
    idle();
    bus.lsb_full_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_dec(OPT_LOAD, 6'h03, 5'd0, 5'd0, 5'd5, 32'h100 + 32'(4 * i), 32'(i));
      tick();
    end
    bus.dec_valid_in = 1'b0;
    chk("t3_full_ready", bus.dec_ready_out, 0);
    bus.lsb_full_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("t3_lsb_valid", bus.lsb_valid_out, 1);
      chk("t3_pc_order", bus.iss_pc_out, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("t3_drained", bus.lsb_valid_out, 0);

    // Three queued entries, one flush cycle (with a decoder offer that must be dropped).
    idle();
    bus.rs_full_in = 1'b1;
    for (int i = 0; i < 3; i++) push_arith(5'd0, 5'd1, 32'h300 + 32'(i));
    set_dec(OPT_ARITH, 6'h02, 5'd0, 5'd0, 5'd1, 32'h3ff, 32'h0);
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    bus.dec_valid_in = 1'b0;
    chk("t4_ready_after_flush", bus.dec_ready_out, 1);
    bus.rs_full_in = 1'b0;
    tick();
    chk("t4_no_issue", bus.rs_valid_out, 0);
    tick();
    chk("t4_no_issue2", bus.rs_valid_out, 0);
    bus.rs_full_in = 1'b1;
    for (int i = 0; i < 3; i++) push_arith(5'd0, 5'd1, 32'h400 + 32'(i));
    chk("t4_count3_ready", bus.dec_ready_out, 1);
    push_arith(5'd0, 5'd1, 32'h403);
    chk("t4_count4_full", bus.dec_ready_out, 0);
    bus.rs_full_in = 1'b0;
    repeat (DEPTH + 1) tick();

    // ROB full blocks the head; rd=0 dispatch gives no rename pulse.
    idle();
    bus.rob_full_in = 1'b1;
    push_arith(5'd0, 5'd0, 32'h500);
    #1;
    chk("t5_no_alloc", bus.rob_alloc_out, 0);
    tick();
    bus.rob_full_in = 1'b0;
    #1;
    chk("t5_alloc", bus.rob_alloc_out, 1);
    chk("t5_no_rename", bus.rf_rename_valid_out, 0);
    tick();
    chk("t5_issue", bus.rs_valid_out, 1);
    chk("t5_issue_pc", bus.iss_pc_out, 32'h500);

    // Reset with a full queue overrides flush and rdy.
    idle();
    bus.rs_full_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_arith(5'd1, 5'd2, 32'h600 + 32'(i));
    rst = 1'b1;
    bus.flush_in = 1'b1;
    bus.rdy_in = 1'b0;
    tick();
    idle();
    chk("t6_ready_after_rst", bus.dec_ready_out, 1);
    chk("t6_pc_zero", bus.iss_pc_out, 0);
    tick();
    chk("t6_no_issue", bus.rs_valid_out, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      tick();
    end
    idle();
    repeat (DEPTH + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
